// File: rtl/fifo_pack_pkg.sv
// rtl/fifo_pack_pkg.sv - shared types and constants for the byte-to-word packer
// Purpose: packer state encoding, byte width and default sizing constants.
// Ports: none (package).
package fifo_pack_pkg;

  localparam int BYTE_W             = 8;
  localparam int DEF_BYTES_PER_WORD = 4;
  localparam int DEF_FLUSH_CYCLES   = 16;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } pack_state_e;

endpackage

// File: rtl/pack_flush_timer.sv
// rtl/pack_flush_timer.sv - idle-cycle counter that triggers a partial-word flush
// Purpose: counts enabled cycles and flags expiry on the CYCLES-th one.
// Ports:
//   clk     in  clock
//   rst     in  asynchronous active-low reset
//   clear   in  zero the count (takes priority over enable)
//   enable  in  count this cycle
//   expire  out high during the enabled cycle that completes CYCLES idle cycles
module pack_flush_timer #(
  parameter int CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CNT_W = $clog2(CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign expire = enable && !clear && (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !expire) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/fifo_word_packer.sv
// rtl/fifo_word_packer.sv - drains a byte FIFO and packs bytes into little-endian words
// Purpose: pops bytes (1-cycle registered FIFO read), packs BYTES_PER_WORD of them
//   with the first byte in lane 0, and presents each word on a valid/ready port.
//   Optional macro PACKER_FLUSH_EN: after FLUSH_CYCLES idle cycles a partial word
//   is emitted with out_keep marking the filled lanes.
// Ports:
//   clk         in   clock shared with the FIFO
//   rst         in   asynchronous active-low reset
//   fifo_empty  in   FIFO empty flag
//   fifo_data   in   FIFO read data, valid the cycle after fifo_rd
//   fifo_rd     out  FIFO pop request
//   out_data    out  packed word
//   out_keep    out  per-byte valid mask
//   out_valid   out  word available
//   out_ready   in   consumer accepts word when out_valid && out_ready
module fifo_word_packer
  import fifo_pack_pkg::*;
#(
  parameter int BYTES_PER_WORD = DEF_BYTES_PER_WORD,
  parameter int OUT_W          = 32,
  parameter int FLUSH_CYCLES   = DEF_FLUSH_CYCLES
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      fifo_empty,
  input  logic [BYTE_W-1:0]         fifo_data,
  output logic                      fifo_rd,
  output logic [OUT_W-1:0]          out_data,
  output logic [BYTES_PER_WORD-1:0] out_keep,
  output logic                      out_valid,
  input  logic                      out_ready
);

  localparam int CW = $clog2(BYTES_PER_WORD) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(BYTES_PER_WORD);
  localparam logic [BYTES_PER_WORD-1:0] KEEP_ALL = '1;

  if (OUT_W != BYTE_W * BYTES_PER_WORD || BYTES_PER_WORD < 2 || BYTES_PER_WORD > 8
      || FLUSH_CYCLES < 1) begin : g_bad_cfg
    $error("fifo_word_packer: illegal parameter combination");
  end

  pack_state_e               state_q, state_d;
  logic [CW-1:0]             issued_q, issued_d;
  logic [CW-1:0]             captured_q, captured_d;
  logic                      rd_pend_q, rd_pend_d;
  logic [OUT_W-1:0]          data_q, data_d;
  logic [BYTES_PER_WORD-1:0] keep_q, keep_d;
  logic                      valid_q, valid_d;
  logic                      rd_c;

`ifdef PACKER_FLUSH_EN
  logic flush_expire;

  // Idle means: a partial word is waiting, nothing in flight, nothing to pop.
  pack_flush_timer #(
    .CYCLES(FLUSH_CYCLES)
  ) u_flush_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (rd_c || (state_q != FILL)),
    .enable((state_q == FILL) && (captured_q != '0) && !rd_pend_q && fifo_empty),
    .expire(flush_expire)
  );
`endif

  always_comb begin
    state_d    = state_q;
    issued_d   = issued_q;
    captured_d = captured_q;
    data_d     = data_q;
    keep_d     = keep_q;
    valid_d    = valid_q;
    rd_c       = 1'b0;

    case (state_q)
      FILL: begin
        // issued counts pops including the one still in flight, so it caps
        // requests at exactly one word's worth.
        rd_c = !fifo_empty && (issued_q < FULL_CNT);
        if (rd_c) begin
          issued_d = issued_q + CW'(1);
        end
        if (rd_pend_q) begin
          for (int i = 0; i < BYTES_PER_WORD; i++) begin
            if (captured_q == CW'(i)) begin
              data_d[i*BYTE_W +: BYTE_W] = fifo_data;
            end
          end
          captured_d = captured_q + CW'(1);
          if (captured_d == FULL_CNT) begin
            state_d = HOLD;
            valid_d = 1'b1;
            keep_d  = KEEP_ALL;
          end
        end
`ifdef PACKER_FLUSH_EN
        else if (flush_expire) begin
          state_d = HOLD;
          valid_d = 1'b1;
          for (int i = 0; i < BYTES_PER_WORD; i++) begin
            keep_d[i] = (CW'(i) < captured_q);
          end
        end
`endif
      end
      HOLD: begin
        if (out_ready) begin
          state_d    = FILL;
          valid_d    = 1'b0;
          issued_d   = '0;
          captured_d = '0;
          data_d     = '0;
          keep_d     = '0;
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase

    rd_pend_d = rd_c;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= FILL;
      issued_q   <= '0;
      captured_q <= '0;
      rd_pend_q  <= 1'b0;
      data_q     <= '0;
      keep_q     <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      issued_q   <= issued_d;
      captured_q <= captured_d;
      rd_pend_q  <= rd_pend_d;
      data_q     <= data_d;
      keep_q     <= keep_d;
      valid_q    <= valid_d;
    end
  end

  assign fifo_rd   = rd_c;
  assign out_data  = data_q;
  assign out_keep  = keep_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_fifo_word_packer.sv
// tb/tb_fifo_word_packer.sv - directed and random bench for fifo_word_packer with a byte FIFO model
module tb_fifo_word_packer;

  localparam int BPW   = 4;
  localparam int OUT_W = 32;
  localparam int FLUSH = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             fifo_empty;
  logic [7:0]       fifo_data;
  logic             fifo_rd;
  logic [OUT_W-1:0] out_data;
  logic [BPW-1:0]   out_keep;
  logic             out_valid;
  logic             out_ready = 1'b0;

  always #5 clk = ~clk;

  fifo_word_packer #(
    .BYTES_PER_WORD(BPW),
    .OUT_W         (OUT_W),
    .FLUSH_CYCLES  (FLUSH)
  ) dut (
    .clk       (clk),
    .rst       (rst_n),
    .fifo_empty(fifo_empty),
    .fifo_data (fifo_data),
    .fifo_rd   (fifo_rd),
    .out_data  (out_data),
    .out_keep  (out_keep),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // 8-deep byte FIFO model with registered read data
  logic [7:0] mem [8];
  logic [2:0] wptr, rptr;
  logic [3:0] cnt;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_ok, rd_ok, fifo_full;

  assign wr_ok      = wr_en && (cnt < 4'd8);
  assign rd_ok      = fifo_rd && (cnt != 4'd0);
  assign fifo_empty = (cnt == 4'd0);
  assign fifo_full  = (cnt == 4'd8);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0; rptr <= '0; cnt <= '0; fifo_data <= '0;
    end else begin
      if (wr_ok) begin mem[wptr] <= wr_data; wptr <= wptr + 3'd1; end
      if (rd_ok) begin fifo_data <= mem[rptr]; rptr <= rptr + 3'd1; end
      cnt <= cnt + {3'd0, wr_ok} - {3'd0, rd_ok};
    end
  end

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [$];
  logic [BPW-1:0] exp_keep = '1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // monitor: protocol checks and scoreboard, sampled on the falling edge
  int cyc = 0, words = 0, run = 0, max_run = 0, valid_cyc = 0;
  int last_rd_cyc = 0, rise_cyc = 0;
  logic prev_valid = 1'b0, prev_stall = 1'b0;
  logic [OUT_W-1:0] prev_data;
  logic [BPW-1:0]   prev_keep;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0; prev_stall = 1'b0; run = 0;
    end else begin
      logic [OUT_W-1:0] exp_word;
      cyc++;
      if (fifo_rd) begin
        run++;
        if (run > max_run) max_run = run;
        last_rd_cyc = cyc;
        check("pop_when_empty", 32'(fifo_empty), 32'd0);
        check("pop_in_hold", 32'(out_valid), 32'd0);
      end else begin
        run = 0;
      end
      if (out_valid && !prev_valid) rise_cyc = cyc;
      if (out_valid) valid_cyc++;
      if (prev_stall) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data", out_data, prev_data);
        check("stall_keep", 32'(out_keep), 32'(prev_keep));
      end
      if (out_valid && out_ready) begin
        exp_word = '0;
        for (int i = 0; i < BPW; i++) begin
          if (exp_keep[i]) begin
            check("sb_has_byte", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) exp_word[i*8 +: 8] = exp_q.pop_front();
          end
        end
        check("word_data", out_data, exp_word);
        check("word_keep", 32'(out_keep), 32'(exp_keep));
        words++;
      end
      prev_stall = out_valid && !out_ready;
      prev_valid = out_valid;
      prev_data  = out_data;
      prev_keep  = out_keep;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] b);
    wr_en = 1'b1;
    wr_data = b;
    exp_q.push_back(b);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_words(input int target, input int budget, input string tag);
    int n = 0;
    while (words < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(words >= target), 32'd1);
  endtask

  initial begin
    int w0;
    int idle;

    // reset state
    repeat (3) tick();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_rd", 32'(fifo_rd), 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_keep", 32'(out_keep), 32'd0);
    rst_n = 1'b1;
    tick();

    // T1: reset with two bytes captured, fresh word afterwards
    write_byte(8'hE1);
    write_byte(8'hE2);
    repeat (5) tick();
    rst_n = 1'b0;
    @(negedge clk);
    check("t1_valid", 32'(out_valid), 32'd0);
    check("t1_rd", 32'(fifo_rd), 32'd0);
    check("t1_data", out_data, 32'd0);
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    tick();

    // T2: basic pack, back-to-back pops, latency
    out_ready = 1'b1;
    w0 = words; max_run = 0; valid_cyc = 0;
    write_byte(8'h11); write_byte(8'h22); write_byte(8'h33); write_byte(8'h44);
    wait_words(w0 + 1, 20, "t2_timeout");
    repeat (3) tick();
    check("t2_rd_run", 32'(max_run), 32'd4);
    check("t2_valid_cycles", 32'(valid_cyc), 32'd1);
    check("t2_latency", 32'(rise_cyc - last_rd_cyc), 32'd2);

    // T3: backpressure, FIFO fills, three words in order
    out_ready = 1'b0;
    w0 = words;
    for (int i = 0; i < 12; i++) write_byte(8'(i));
    repeat (4) tick();
    check("t3_full", 32'(fifo_full), 32'd1);
    check("t3_valid", 32'(out_valid), 32'd1);
    check("t3_word0", out_data, 32'h03020100);
    repeat (6) tick();
    out_ready = 1'b1;
    wait_words(w0 + 3, 60, "t3_timeout");
    tick();

    // T4: trickle with FIFO empty between bytes
    w0 = words;
    for (int i = 0; i < 4; i++) begin
      write_byte(8'h50 + 8'(i));
      repeat (4) tick();
    end
    wait_words(w0 + 1, 20, "t4_timeout");
    tick();

    // T5: partial word
    w0 = words;
`ifdef PACKER_FLUSH_EN
    exp_keep = 4'b0011;
    write_byte(8'hAA);
    write_byte(8'hBB);
    wait_words(w0 + 1, 40, "t5_flush_timeout");
    check("t5_flush_latency", 32'(rise_cyc - last_rd_cyc), 32'(FLUSH + 2));
    tick();
    exp_keep = '1;
`else
    write_byte(8'hAA);
    write_byte(8'hBB);
    repeat (100) tick();
    check("t5_no_word", 32'(words), 32'(w0));
    check("t5_no_valid", 32'(out_valid), 32'd0);
    write_byte(8'hCC);
    write_byte(8'hDD);
    wait_words(w0 + 1, 20, "t5_complete_timeout");
    tick();
`endif

    // T6: random traffic; a write at least every 8 cycles keeps the flush timer quiet
    idle = 0;
    for (int c = 0; c < 10000; c++) begin
      out_ready = ($urandom_range(3) != 0);
      if (cnt < 4'd8 && (($urandom_range(1) == 1) || idle >= 7)) begin
        idle = 0;
        write_byte(8'($urandom));
      end else begin
        idle++;
        tick();
      end
    end
    out_ready = 1'b1;
    while (exp_q.size() % BPW != 0) write_byte(8'($urandom));
    begin
      int n = 0;
      while (exp_q.size() != 0 && n < 300) begin
        tick();
        n++;
      end
    end
    check("t6_drained", 32'(exp_q.size()), 32'd0);
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
